// File: rtl/nn2_accum_unit.sv
// nn2_accum_unit: registered add/sub/accumulate unit with a valid/ready
// handshake and a single output register. Operands are unsigned. The SAT
// parameter selects between clamping and modulo-2^N wrap on overflow. A
// sticky overflow flag records any overflowing beat until the next CLR or
// the next reset.
module nn2_accum_unit #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter bit SAT       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 overflow
);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic                 valid_reg, valid_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic                 ovf_reg, ovf_next;

    logic                 accept;
    logic [WIDTH:0]       sum_ab;
    logic [WIDTH:0]       diff_ab;
    logic [ACC_WIDTH:0]   acc_sum;

    // The output register can take a new beat when empty or draining this cycle.
    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // One extra bit on each datapath exposes carry (ADD/ACC) and borrow (SUB).
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};
    assign acc_sum = {1'b0, acc_reg}
                   + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, a}
                   + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, b};

    // Next-state selection: hold on stall, empty on drain-only, compute on accept.
    always_comb begin
        valid_next  = valid_reg;
        result_next = result_reg;
        acc_next    = acc_reg;
        ovf_next    = ovf_reg;
        if (accept) begin
            valid_next = 1'b1;
            case (mode)
                MODE_ADD: begin
                    if (sum_ab[WIDTH]) begin
                        result_next = SAT ? {WIDTH{1'b1}} : sum_ab[WIDTH-1:0];
                        ovf_next    = 1'b1;
                    end else begin
                        result_next = sum_ab[WIDTH-1:0];
                    end
                end
                MODE_SUB: begin
                    if (diff_ab[WIDTH]) begin
                        result_next = SAT ? {WIDTH{1'b0}} : diff_ab[WIDTH-1:0];
                        ovf_next    = 1'b1;
                    end else begin
                        result_next = diff_ab[WIDTH-1:0];
                    end
                end
                MODE_ACC: begin
                    // Only a carry out of the accumulator marks overflow; the
                    // narrower result view is clamped or truncated silently.
                    if (acc_sum[ACC_WIDTH]) begin
                        acc_next = SAT ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];
                        ovf_next = 1'b1;
                    end else begin
                        acc_next = acc_sum[ACC_WIDTH-1:0];
                    end
                    if (acc_sum[ACC_WIDTH:WIDTH] == '0) begin
                        result_next = acc_sum[WIDTH-1:0];
                    end else begin
                        result_next = SAT ? {WIDTH{1'b1}} : acc_sum[WIDTH-1:0];
                    end
                end
                MODE_CLR: begin
                    // CLR is the only operation in its beat, so it wins over the sticky flag.
                    acc_next    = '0;
                    result_next = '0;
                    ovf_next    = 1'b0;
                end
                default: begin
                    result_next = result_reg;
                end
            endcase
        end else if (out_ready) begin
            valid_next = 1'b0;
        end
    end

    // State registers; reset drops any pending beat immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            result_reg <= '0;
            acc_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            valid_reg  <= valid_next;
            result_reg <= result_next;
            acc_reg    <= acc_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign out_valid = valid_reg;
    assign result    = result_reg;
    assign acc       = acc_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_nn2_accum_unit.sv
// Bench for nn2_accum_unit: a wrap instance and a saturate instance share
// stimulus. Accepted beats push expected values from an arithmetic model into
// a queue; a negedge monitor pops and compares whenever a beat is consumed.
module tb_nn2_accum_unit;

    localparam int W  = 8;
    localparam int AW = 16;
    localparam longint RMAX = (longint'(1) << W) - 1;
    localparam longint AMAX = (longint'(1) << AW) - 1;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [1:0] mode = ADD;
    logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [W-1:0] result0, result1;
    logic [AW-1:0] acc0, acc1;

    always #5 clk = ~clk;

    nn2_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .acc(acc0), .overflow(ovf0)
    );

    nn2_accum_unit #(.WIDTH(W), .ACC_WIDTH(AW), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .acc(acc1), .overflow(ovf1)
    );

    typedef struct {
        longint r0, r1, ac0, ac1;
        bit     ov0, ov1;
    } exp_t;

    exp_t   q[$];
    longint m_acc0 = 0, m_acc1 = 0;
    bit     m_ov0 = 0, m_ov1 = 0;
    int     total = 0, bad = 0;

    task automatic check(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference rules for one accepted beat, evaluated for one SAT setting.
    function automatic void model_one(input bit sat, input logic [1:0] m, input longint av,
                                      input longint bv, inout longint accv, inout bit ov,
                                      output longint r);
        longint s;
        r = 0;
        case (m)
            ADD: begin
                s = av + bv;
                if (s > RMAX) begin r = sat ? RMAX : s % (RMAX + 1); ov = 1; end
                else r = s;
            end
            SUB: begin
                if (av < bv) begin r = sat ? 0 : av - bv + RMAX + 1; ov = 1; end
                else r = av - bv;
            end
            ACC: begin
                s = accv + av + bv;
                if (s > AMAX) begin accv = sat ? AMAX : s - (AMAX + 1); ov = 1; end
                else accv = s;
                r = (s <= RMAX) ? s : (sat ? RMAX : s % (RMAX + 1));
            end
            default: begin accv = 0; ov = 0; r = 0; end
        endcase
    endfunction

    function automatic void model_accept(input logic [1:0] m, input longint av, input longint bv);
        exp_t e;
        model_one(1'b0, m, av, bv, m_acc0, m_ov0, e.r0);
        model_one(1'b1, m, av, bv, m_acc1, m_ov1, e.r1);
        e.ac0 = m_acc0; e.ac1 = m_acc1; e.ov0 = m_ov0; e.ov1 = m_ov1;
        q.push_back(e);
    endfunction

    // One stimulus cycle: drive after the edge, decide acceptance at the negedge.
    task automatic cycle(input bit iv, input int ia, input int ib, input logic [1:0] im,
                         input bit ordy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        a         = W'(ia);
        b         = W'(ib);
        mode      = im;
        out_ready = ordy;
        @(negedge clk);
        if (in_valid && in_ready0) model_accept(mode, longint'(a), longint'(b));
    endtask

    // Monitor: handshake rules every cycle, scoreboard compare on each consumed beat.
    bit             prev_stall = 0;
    logic [W-1:0]   prev_r0 = '0, prev_r1 = '0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            check("in_ready_rule", longint'(in_ready0), longint'(!out_valid0 || out_ready));
            check("in_ready_match", longint'(in_ready1), longint'(in_ready0));
            check("out_valid_match", longint'(out_valid1), longint'(out_valid0));
            if (prev_stall) begin
                check("stall_hold_r0", longint'(result0), longint'(prev_r0));
                check("stall_hold_r1", longint'(result1), longint'(prev_r1));
            end
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("beat r0=%0d r1=%0d acc0=%0d acc1=%0d ov0=%0d ov1=%0d",
                             result0, result1, acc0, acc1, ovf0, ovf1);
                    check("result_wrap", longint'(result0), e.r0);
                    check("result_sat", longint'(result1), e.r1);
                    check("acc_wrap", longint'(acc0), e.ac0);
                    check("acc_sat", longint'(acc1), e.ac1);
                    check("ovf_wrap", longint'(ovf0), longint'(e.ov0));
                    check("ovf_sat", longint'(ovf1), longint'(e.ov1));
                end
            end
            prev_stall = out_valid0 && !out_ready;
            prev_r0    = result0;
            prev_r1    = result1;
        end
    end

    initial begin
        int r, av, bv;
        logic [1:0] m;
        #12;
        check("reset_out_valid", longint'(out_valid0), 0);
        check("reset_result", longint'(result1), 0);
        check("reset_acc", longint'(acc1), 0);
        check("reset_ovf", longint'(ovf1), 0);
        @(posedge clk); #3 rst = 1'b0;

        // ADD overflow in both arithmetic flavours
        cycle(1, 200, 100, ADD, 1);
        cycle(0, 0, 0, ADD, 1);
        check("add_sat_255", longint'(result1), 255);
        check("add_wrap_44", longint'(result0), 44);
        check("add_ovf_set", longint'(ovf1), 1);

        // SUB underflow
        cycle(1, 5, 7, SUB, 1);
        cycle(0, 0, 0, ADD, 1);
        check("sub_wrap_254", longint'(result0), 254);
        check("sub_sat_0", longint'(result1), 0);

        // ACC stream then CLR
        cycle(1, 0, 0, CLR, 1);
        for (int i = 0; i < 10; i++) cycle(1, 100, 100, ACC, 1);
        cycle(0, 0, 0, ADD, 1);
        check("acc_2000_sat", longint'(acc1), 2000);
        check("acc_2000_wrap", longint'(acc0), 2000);
        cycle(1, 9, 9, SUB, 1);
        cycle(1, 0, 0, CLR, 1);
        cycle(0, 0, 0, ADD, 1);
        check("clr_acc", longint'(acc1), 0);
        check("clr_ovf", longint'(ovf1), 0);
        check("clr_result", longint'(result1), 0);

        // Backpressure: three stalled cycles with a beat waiting
        cycle(1, 11, 22, ADD, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 33 + i, 1, ADD, 0);
            check("stall_in_ready", longint'(in_ready0), 0);
        end
        for (int i = 0; i < 3; i++) cycle(1, 50 + i, 2, SUB, 1);

        // Back-to-back ADD at full throughput
        for (int i = 0; i < 6; i++) begin
            cycle(1, 40 * i, 7, ADD, 1);
            check("b2b_in_ready", longint'(in_ready0), 1);
        end
        cycle(0, 0, 0, ADD, 1);

        // Accumulator carry-out
        cycle(1, 0, 0, CLR, 1);
        for (int i = 0; i < 140; i++) cycle(1, 255, 255, ACC, 1);
        cycle(0, 0, 0, ADD, 1);
        check("acc_sat_max", longint'(acc1), 65535);
        check("acc_wrap_5864", longint'(acc0), 5864);
        check("acc_carry_ovf", longint'(ovf0), 1);

        // Reset during a stall with acc=37
        cycle(1, 0, 0, CLR, 1);
        cycle(1, 20, 17, ACC, 1);
        cycle(0, 0, 0, ADD, 0);
        cycle(0, 0, 0, ADD, 0);
        check("pre_rst_acc37", longint'(acc0), 37);
        check("pre_rst_valid", longint'(out_valid0), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", longint'(out_valid0), 0);
        check("rst_async_acc", longint'(acc0), 0);
        check("rst_async_acc_sat", longint'(acc1), 0);
        q.delete();
        m_acc0 = 0; m_acc1 = 0; m_ov0 = 0; m_ov1 = 0;
        @(posedge clk); #3 rst = 1'b0;
        #1 check("post_rst_in_ready", longint'(in_ready0), 1);
        cycle(1, 3, 4, ACC, 1);
        cycle(0, 0, 0, ADD, 1);
        check("post_rst_acc", longint'(acc1), 7);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            r  = $urandom_range(0, 15);
            m  = (r < 5) ? ADD : (r < 10) ? SUB : (r < 15) ? ACC : CLR;
            av = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 255 : 0)
                                             : int'($urandom_range(0, 255));
            bv = int'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, av, bv, m, $urandom_range(0, 3) != 0);
        end

        // Drain and confirm nothing was lost
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, ADD, 1);
        check("queue_drained", longint'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
